// File: rtl/lau_pkg.sv
// lau_pkg: shared types for the Gray/binary conversion pipeline.
//   speed_e     - architecture choice for PrefixXor (FAST = log-depth tree,
//                 SMALL = linear ripple chain)
//   gray_mode_e - per-beat conversion direction (G2B = Gray->binary,
//                 B2G = binary->Gray)
package lau_pkg;

    typedef enum logic {
        FAST  = 1'b0,
        SMALL = 1'b1
    } speed_e;

    typedef enum logic {
        G2B = 1'b0,
        B2G = 1'b1
    } gray_mode_e;

endpackage

// File: rtl/gray_conv_stage.sv
// gray_conv_stage: one register slice of gray_conv_pipe.
// Resolves result bits [HI:LO] for G2B beats by combining the segment-local
// prefix XOR with the running prefix from the slice above; B2G beats pass
// through untouched. HI < LO marks an empty slice (pure register), which
// happens when STAGES does not divide WIDTH evenly.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid / in_ready     upstream handshake (in_ready = load enable)
//   in_mode, in_raw         beat mode and original input word
//   in_res, in_pre, in_err  partial result, running prefix, sequence error
//   out_valid / out_ready   downstream handshake
//   out_*                   registered copies of the above
module gray_conv_stage
    import lau_pkg::*;
#(
    parameter int     WIDTH = 8,
    parameter int     LO    = 0,
    parameter int     HI    = 7,
    parameter speed_e SPEED = FAST
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  gray_mode_e       in_mode,
    input  logic [WIDTH-1:0] in_raw,
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_pre,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output gray_mode_e       out_mode,
    output logic [WIDTH-1:0] out_raw,
    output logic [WIDTH-1:0] out_res,
    output logic             out_pre,
    output logic             out_err
);

    logic [WIDTH-1:0] res_next;
    logic             pre_next;

    if (HI >= LO) begin : g_seg
        localparam int SW = HI - LO + 1;
        logic [SW-1:0] seg_px;

        PrefixXor #(.WIDTH(SW), .SPEED(SPEED)) u_px (
            .data  (in_raw[HI:LO]),
            .prefix(seg_px)
        );

        always_comb begin
            res_next = in_res;
            pre_next = in_pre;
            if (in_mode == G2B) begin
                res_next[HI:LO] = seg_px ^ {SW{in_pre}};
                // Next slice needs the XOR of everything above it.
                pre_next        = res_next[LO];
            end
        end
    end else begin : g_pass
        assign res_next = in_res;
        assign pre_next = in_pre;
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
            out_mode  <= G2B;
            out_raw   <= '0;
            out_res   <= '0;
            out_pre   <= 1'b0;
            out_err   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            // Payload only moves with a real beat so idle data never leaks in.
            if (in_valid) begin
                out_mode <= in_mode;
                out_raw  <= in_raw;
                out_res  <= res_next;
                out_pre  <= pre_next;
                out_err  <= in_err;
            end
        end
    end

endmodule

// File: rtl/prefix_xor.sv
// PrefixXor: MSB-first prefix XOR, prefix[i] = ^data[WIDTH-1:i].
// Ports:
//   data   in  WIDTH  input word
//   prefix out WIDTH  running XOR from the MSB down to each bit
// SPEED=FAST builds a Kogge-Stone style log2(WIDTH)-level tree;
// SPEED=SMALL builds a single ripple chain.
module PrefixXor
    import lau_pkg::*;
#(
    parameter int     WIDTH = 8,
    parameter speed_e SPEED = FAST
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] prefix
);

    if (SPEED == FAST) begin : g_fast
        localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 0;
        logic [LV:0][WIDTH-1:0] lvl;

        assign lvl[0] = data;
        // Level l folds in the partial result 2^l bits further toward the MSB.
        for (genvar l = 0; l < LV; l++) begin : g_lvl
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i + (1 << l) < WIDTH) begin : g_x
                    assign lvl[l+1][i] = lvl[l][i] ^ lvl[l][i+(1<<l)];
                end else begin : g_p
                    assign lvl[l+1][i] = lvl[l][i];
                end
            end
        end
        assign prefix = lvl[LV];
    end else begin : g_small
        always_comb begin
            logic acc;
            acc    = 1'b0;
            prefix = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                acc       = acc ^ data[i];
                prefix[i] = acc;
            end
        end
    end

endmodule

// File: rtl/gray_conv_pipe.sv
// gray_conv_pipe: pipelined bidirectional Gray/binary converter with
// valid/ready streaming. Latency is STAGES cycles, throughput 1 beat/cycle.
// Optional macro: GRAY_CONV_SEQ_CHECK_EN enables the Gray-sequence checker
// (out_err_o flags a G2B beat that differs from the previous G2B beat in
// other than exactly one bit); without it out_err_o is constant 0.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i / in_ready_o    input handshake
//   in_mode_i, in_data_i       conversion direction and input word
//   out_valid_o / out_ready_i  output handshake
//   out_mode_o, out_data_o     mode and converted word of the output beat
//   out_err_o                  Gray-sequence error flag
module gray_conv_pipe
    import lau_pkg::*;
#(
    parameter int     WIDTH  = 8,
    parameter int     STAGES = 2,
    parameter speed_e SPEED  = FAST
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  gray_mode_e       in_mode_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output gray_mode_e       out_mode_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_err_o
);

    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    // Index 0 is the pipe input, index STAGES the pipe output.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            rdy_pipe;
    logic [STAGES:0]            pre_pipe;
    logic [STAGES:0]            err_pipe;
    gray_mode_e                 mode_pipe [STAGES+1];
    logic [STAGES:0][WIDTH-1:0] raw_pipe;
    logic [STAGES:0][WIDTH-1:0] res_pipe;

    assign vld_pipe[0]      = in_valid_i;
    assign mode_pipe[0]     = in_mode_i;
    assign raw_pipe[0]      = in_data_i;
    // B2G is a single XOR level, so it is finished before the first slice.
    assign res_pipe[0]      = (in_mode_i == B2G) ? (in_data_i ^ (in_data_i >> 1)) : '0;
    assign pre_pipe[0]      = 1'b0;
    assign rdy_pipe[STAGES] = out_ready_i;
    assign in_ready_o       = rdy_pipe[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int HI = WIDTH - 1 - s * SEG;
        localparam int LO = (HI - SEG + 1 > 0) ? HI - SEG + 1 : 0;

        gray_conv_stage #(
            .WIDTH(WIDTH),
            .LO   (LO),
            .HI   (HI),
            .SPEED(SPEED)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .in_valid (vld_pipe[s]),
            .in_ready (rdy_pipe[s]),
            .in_mode  (mode_pipe[s]),
            .in_raw   (raw_pipe[s]),
            .in_res   (res_pipe[s]),
            .in_pre   (pre_pipe[s]),
            .in_err   (err_pipe[s]),
            .out_valid(vld_pipe[s+1]),
            .out_ready(rdy_pipe[s+1]),
            .out_mode (mode_pipe[s+1]),
            .out_raw  (raw_pipe[s+1]),
            .out_res  (res_pipe[s+1]),
            .out_pre  (pre_pipe[s+1]),
            .out_err  (err_pipe[s+1])
        );
    end

`ifdef GRAY_CONV_SEQ_CHECK_EN
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] last_g;
    logic [WIDTH-1:0] diff;
    logic             have_last;

    assign diff = in_data_i ^ last_g;
    // Exactly one bit set <=> non-zero and power of two.
    assign err_pipe[0] = (in_mode_i == G2B) && have_last &&
                         !((diff != '0) && ((diff & (diff - ONE)) == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_g    <= '0;
            have_last <= 1'b0;
        end else if (in_valid_i && in_ready_o && (in_mode_i == G2B)) begin
            last_g    <= in_data_i;
            have_last <= 1'b1;
        end
    end
`else
    // Error bit enters as constant 0, so the carried flag is constant 0.
    assign err_pipe[0] = 1'b0;
`endif

    assign out_valid_o = vld_pipe[STAGES];
    assign out_mode_o  = mode_pipe[STAGES];
    assign out_data_o  = res_pipe[STAGES];
    assign out_err_o   = err_pipe[STAGES];

    // Raw word and running prefix are not needed past the last slice.
    logic unused_tail;
    assign unused_tail = ^{raw_pipe[STAGES], pre_pipe[STAGES]};

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Testbench for gray_conv_pipe: four instances (STAGES = 2,1,3,8) share one
// input stream; a negedge monitor records accepted and emitted beats per
// instance, and each test task compares against a plain-arithmetic model.
module tb_gray_conv_pipe;
    import lau_pkg::*;

    localparam int NK = 4;
    localparam int W  = 8;
`ifdef GRAY_CONV_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    function automatic int stg(int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 8;
        endcase
    endfunction

    typedef struct {
        gray_mode_e     mode;
        logic [W-1:0]   data;
        logic           err;
        int             cyc;
    } beat_t;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    gray_mode_e       in_mode   = G2B;
    logic [W-1:0]     in_data   = '0;
    logic [NK-1:0]    in_ready;
    logic [NK-1:0]    out_valid;
    logic [NK-1:0]    out_err;
    gray_mode_e       out_mode [NK];
    logic [W-1:0]     out_data [NK];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        gray_conv_pipe #(
            .WIDTH (W),
            .STAGES(stg(k)),
            .SPEED ((k == 2) ? SMALL : FAST)
        ) dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready[k]),
            .in_mode_i  (in_mode),
            .in_data_i  (in_data),
            .out_valid_o(out_valid[k]),
            .out_ready_i(out_ready),
            .out_mode_o (out_mode[k]),
            .out_data_o (out_data[k]),
            .out_err_o  (out_err[k])
        );
    end

    // Reference model straight from the code definitions.
    function automatic logic [W-1:0] g2b(logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] conv(gray_mode_e m, logic [W-1:0] d);
        return (m == G2B) ? g2b(d) : b2g(d);
    endfunction

    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    beat_t        acc_q [NK][$];
    beat_t        out_q [NK][$];
    logic [W-1:0] m_last [NK];
    bit           m_have [NK];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records handshakes and computes the expected sequence flag.
    always @(negedge clk) begin
        beat_t bt;
        for (int k = 0; k < NK; k++) begin
            if (rst) begin
                m_have[k] = 1'b0;
            end else begin
                if (in_valid && in_ready[k]) begin
                    bt.mode = in_mode;
                    bt.data = in_data;
                    bt.err  = 1'b0;
                    bt.cyc  = cyc;
                    if (in_mode == G2B) begin
                        if (SEQ && m_have[k]) bt.err = ($countones(in_data ^ m_last[k]) != 1);
                        m_last[k] = in_data;
                        m_have[k] = 1'b1;
                    end
                    acc_q[k].push_back(bt);
                end
                if (out_valid[k] && out_ready) begin
                    bt.mode = out_mode[k];
                    bt.data = out_data[k];
                    bt.err  = out_err[k];
                    bt.cyc  = cyc;
                    out_q[k].push_back(bt);
                end
            end
        end
    end

    task automatic drive(input logic v, input gray_mode_e m, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        in_valid = v;
        in_mode  = m;
        in_data  = d;
    endtask

    task automatic drain();
        drive(1'b0, G2B, '0);
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        for (int k = 0; k < NK; k++) begin
            acc_q[k].delete();
            out_q[k].delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            checks += 5;
            if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid k=%0d got=%0b exp=0", k, out_valid[k]); end
            if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready k=%0d got=%0b exp=1", k, in_ready[k]); end
            if (out_data[k] !== 8'h00) begin errors++; $display("FAIL reset_out_data k=%0d got=%h exp=00", k, out_data[k]); end
            if (out_mode[k] !== G2B) begin errors++; $display("FAIL reset_out_mode k=%0d got=%0d exp=0", k, out_mode[k]); end
            if (out_err[k] !== 1'b0) begin errors++; $display("FAIL reset_out_err k=%0d got=%0b exp=0", k, out_err[k]); end
        end
    endtask

    task automatic test_first_beat();
        clear_q();
        out_ready = 1'b1;
        drive(1'b1, G2B, 8'hC0);
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL first_accept got=%0b exp=1", in_ready[0]); end
        drive(1'b0, G2B, 8'h00);
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL first_early_valid got=%0b exp=0", out_valid[0]); end
        @(negedge clk);
        checks += 3;
        if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL first_valid got=%0b exp=1", out_valid[0]); end
        if (out_data[0] !== 8'h80) begin errors++; $display("FAIL first_data got=%h exp=80", out_data[0]); end
        if (out_mode[0] !== G2B) begin errors++; $display("FAIL first_mode got=%0d exp=0", out_mode[0]); end
        drain();
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (out_q[k].size() != 1 || acc_q[k].size() != 1) begin
                errors++;
                $display("FAIL first_count k=%0d got=%0d exp=1", k, out_q[k].size());
            end else begin
                checks += 2;
                if (out_q[k][0].data !== 8'h80) begin errors++; $display("FAIL first_q_data k=%0d got=%h exp=80", k, out_q[k][0].data); end
                if (out_q[k][0].cyc - acc_q[k][0].cyc != stg(k)) begin
                    errors++;
                    $display("FAIL first_latency k=%0d got=%0d exp=%0d", k, out_q[k][0].cyc - acc_q[k][0].cyc, stg(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        drive(1'b1, G2B, 8'h0F);
        drive(1'b1, B2G, 8'h0A);
        drain();
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (out_q[k].size() != 2) begin
                errors++;
                $display("FAIL b2b_count k=%0d got=%0d exp=2", k, out_q[k].size());
            end else begin
                checks += 5;
                if (out_q[k][0].data !== 8'h0A) begin errors++; $display("FAIL b2b_data0 k=%0d got=%h exp=0a", k, out_q[k][0].data); end
                if (out_q[k][0].mode !== G2B) begin errors++; $display("FAIL b2b_mode0 k=%0d got=%0d exp=0", k, out_q[k][0].mode); end
                if (out_q[k][1].data !== 8'h0F) begin errors++; $display("FAIL b2b_data1 k=%0d got=%h exp=0f", k, out_q[k][1].data); end
                if (out_q[k][1].mode !== B2G) begin errors++; $display("FAIL b2b_mode1 k=%0d got=%0d exp=1", k, out_q[k][1].mode); end
                if (out_q[k][1].cyc != out_q[k][0].cyc + 1) begin
                    errors++;
                    $display("FAIL b2b_gap k=%0d got=%0d exp=1", k, out_q[k][1].cyc - out_q[k][0].cyc);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] bd [4];
        gray_mode_e   bm [4];
        int           idx;
        int           budget;
        clear_q();
        for (int j = 0; j < 4; j++) begin
            bd[j] = W'($urandom);
            bm[j] = gray_mode_e'($urandom_range(0, 1));
        end
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bm[idx], bd[idx]);
            out_ready = 1'b0;
            @(negedge clk);
            if (in_ready[0]) idx++;
            if (i >= 2) begin
                checks += 3;
                if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_in_ready i=%0d got=%0b exp=0", i, in_ready[0]); end
                if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL stall_hold_valid i=%0d got=%0b exp=1", i, out_valid[0]); end
                if (out_data[0] !== conv(bm[0], bd[0])) begin
                    errors++;
                    $display("FAIL stall_hold_data i=%0d got=%h exp=%h", i, out_data[0], conv(bm[0], bd[0]));
                end
            end
        end
        checks++;
        if (idx != 2) begin errors++; $display("FAIL stall_accepted got=%0d exp=2", idx); end
        budget = 0;
        while (idx < 4 && budget < 20) begin
            drive(1'b1, bm[idx], bd[idx]);
            out_ready = 1'b1;
            @(negedge clk);
            if (in_ready[0]) idx++;
            budget++;
        end
        checks++;
        if (idx != 4) begin errors++; $display("FAIL stall_timeout got=%0d exp=4", idx); end
        drain();
        checks++;
        if (out_q[0].size() != 4) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=4", out_q[0].size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks += 2;
                if (out_q[0][j].data !== conv(bm[j], bd[j])) begin
                    errors++;
                    $display("FAIL stall_order j=%0d got=%h exp=%h", j, out_q[0][j].data, conv(bm[j], bd[j]));
                end
                if (out_q[0][j].mode !== bm[j]) begin
                    errors++;
                    $display("FAIL stall_mode j=%0d got=%0d exp=%0d", j, out_q[0][j].mode, bm[j]);
                end
            end
        end
    endtask

    task automatic test_reset_flight();
        clear_q();
        out_ready = 1'b0;
        drive(1'b1, G2B, W'($urandom));
        out_ready = 1'b0;
        drive(1'b1, B2G, W'($urandom));
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            checks += 2;
            if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL flight_out_valid k=%0d got=%0b exp=0", k, out_valid[k]); end
            if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL flight_in_ready k=%0d got=%0b exp=1", k, in_ready[k]); end
        end
        drain();
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (out_q[k].size() != 0) begin errors++; $display("FAIL flight_dropped k=%0d got=%0d exp=0", k, out_q[k].size()); end
        end
    endtask

    task automatic test_seq_check();
        logic [W-1:0] seq [4];
        logic [3:0]   exp_err;
        seq[0] = 8'h00; seq[1] = 8'h01; seq[2] = 8'h03; seq[3] = 8'h00;
        exp_err = SEQ ? 4'b1000 : 4'b0000;
        do_reset();
        clear_q();
        for (int j = 0; j < 4; j++) drive(1'b1, G2B, seq[j]);
        drain();
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (out_q[k].size() != 4) begin
                errors++;
                $display("FAIL seq_count k=%0d got=%0d exp=4", k, out_q[k].size());
            end else begin
                for (int j = 0; j < 4; j++) begin
                    checks += 2;
                    if (out_q[k][j].err !== exp_err[j]) begin
                        errors++;
                        $display("FAIL seq_err k=%0d j=%0d got=%0b exp=%0b", k, j, out_q[k][j].err, exp_err[j]);
                    end
                    if (out_q[k][j].data !== g2b(seq[j])) begin
                        errors++;
                        $display("FAIL seq_data k=%0d j=%0d got=%h exp=%h", k, j, out_q[k][j].data, g2b(seq[j]));
                    end
                end
            end
        end
    endtask

    task automatic test_exhaustive();
        clear_q();
        out_ready = 1'b1;
        for (int x = 0; x < 256; x++) drive(1'b1, G2B, W'(x));
        for (int x = 0; x < 256; x++) drive(1'b1, B2G, g2b(W'(x)));
        drain();
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (out_q[k].size() != 512 || acc_q[k].size() != 512) begin
                errors++;
                $display("FAIL exh_count k=%0d got=%0d exp=512", k, out_q[k].size());
            end else begin
                for (int j = 0; j < 512; j++) begin
                    logic [W-1:0] e;
                    e = (j < 256) ? g2b(W'(j)) : W'(j - 256);
                    checks += 2;
                    if (out_q[k][j].data !== e) begin
                        errors++;
                        $display("FAIL exh_data k=%0d j=%0d got=%h exp=%h", k, j, out_q[k][j].data, e);
                    end
                    if (out_q[k][j].cyc - acc_q[k][j].cyc != stg(k)) begin
                        errors++;
                        $display("FAIL exh_latency k=%0d j=%0d got=%0d exp=%0d", k, j,
                                 out_q[k][j].cyc - acc_q[k][j].cyc, stg(k));
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int n;
        clear_q();
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 9) < 7), gray_mode_e'($urandom_range(0, 1)), W'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
        end
        drain();
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (out_q[k].size() != acc_q[k].size()) begin
                errors++;
                $display("FAIL rand_count k=%0d got=%0d exp=%0d", k, out_q[k].size(), acc_q[k].size());
            end
            n = (out_q[k].size() < acc_q[k].size()) ? out_q[k].size() : acc_q[k].size();
            for (int j = 0; j < n; j++) begin
                checks += 3;
                if (out_q[k][j].data !== conv(acc_q[k][j].mode, acc_q[k][j].data)) begin
                    errors++;
                    $display("FAIL rand_data k=%0d j=%0d got=%h exp=%h", k, j, out_q[k][j].data,
                             conv(acc_q[k][j].mode, acc_q[k][j].data));
                end
                if (out_q[k][j].mode !== acc_q[k][j].mode) begin
                    errors++;
                    $display("FAIL rand_mode k=%0d j=%0d got=%0d exp=%0d", k, j, out_q[k][j].mode, acc_q[k][j].mode);
                end
                if (out_q[k][j].err !== acc_q[k][j].err) begin
                    errors++;
                    $display("FAIL rand_err k=%0d j=%0d got=%0b exp=%0b", k, j, out_q[k][j].err, acc_q[k][j].err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_seq_check();
        test_exhaustive();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
